// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: instruction memory port, redirect input and instruction queue output.
// The master modport is the fetch unit; the slave modport is its environment.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory request at a time, results queued
// in a small FIFO with their PCs; a redirect flushes the queue and drops in-flight data.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input logic           clk,
    input logic           reset,
    instr_fetch_if.master bus
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {StFetch, StWait, StDrop} state_e;

    state_e        state_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   req_pc_q;
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic [31:0]   q_pc_q    [QDEPTH];
    logic [31:0]   q_instr_q [QDEPTH];

    logic        redirect;
    logic [31:0] redirect_pc_aligned;
    logic        have_space;
    logic        issue;
    logic        push;
    logic        pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(QDEPTH - 1)) return '0;
        return p + PW'(1);
    endfunction

    assign redirect            = bus.redirect_valid;
    assign redirect_pc_aligned = {bus.redirect_pc[31:2], 2'b00};
    assign have_space          = count_q < CW'(QDEPTH);

    // Requests are only raised with free queue space, so a push can never overflow.
    assign bus.imem_req  = !reset && (state_q == StFetch) && have_space && !redirect;
    assign bus.imem_addr = fetch_pc_q;
    assign issue         = bus.imem_req && bus.imem_gnt;
    assign push          = (state_q == StWait) && bus.imem_rvalid && !redirect;
    assign pop           = bus.out_valid && bus.out_ready;

    assign bus.out_valid = !reset && (count_q != '0);
    assign bus.out_instr = bus.out_valid ? q_instr_q[head_q] : '0;
    assign bus.out_pc    = bus.out_valid ? q_pc_q[head_q] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StFetch;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            case (state_q)
                StFetch: begin
                    if (issue) begin
                        req_pc_q <= fetch_pc_q;
                        state_q  <= redirect ? StDrop : StWait;
                    end
                end
                StWait: begin
                    if (bus.imem_rvalid) state_q <= StFetch;
                    else if (redirect)   state_q <= StDrop;
                end
                StDrop: begin
                    if (bus.imem_rvalid) state_q <= StFetch;
                end
                default: state_q <= StFetch;
            endcase

            if (redirect)   fetch_pc_q <= redirect_pc_aligned;
            else if (issue) fetch_pc_q <= fetch_pc_q + 32'd4;

            // Flush wins over a same-cycle pop; the popped head is still consumed downstream.
            if (redirect) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    q_pc_q[tail_q]    <= req_pc_q;
                    q_instr_q[tail_q] <= bus.imem_rdata;
                    tail_q            <= ptr_inc(tail_q);
                end
                if (pop) head_q <= ptr_inc(head_q);
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: straight-line fetch, backpressure, redirects,
// PC wrap-around and mid-operation reset.
module tb_instr_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    instr_fetch_if bus_a ();
    instr_fetch_if bus_w ();

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    instr_fetch #(
        .RESET_PC (32'hFFFF_FFFC),
        .QDEPTH   (2)
    ) u_dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_w)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic        mem_auto;
    logic        gnt_m;
    logic        rv_m;
    logic [31:0] rdata_m;
    logic        redir_m;
    logic [31:0] rpc_m;
    logic        ready_m;

    logic        pend_a;
    logic [31:0] addr_a;
    logic        pend_w;
    logic [31:0] addr_w;
    int          grants_a;

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    // Auto memory: grants every request, returns data one cycle after the grant.
    assign bus_a.imem_gnt       = mem_auto ? bus_a.imem_req : gnt_m;
    assign bus_a.imem_rvalid    = mem_auto ? pend_a : rv_m;
    assign bus_a.imem_rdata     = mem_auto ? word_at(addr_a) : rdata_m;
    assign bus_a.redirect_valid = redir_m;
    assign bus_a.redirect_pc    = rpc_m;
    assign bus_a.out_ready      = ready_m;

    assign bus_w.imem_gnt       = bus_w.imem_req;
    assign bus_w.imem_rvalid    = pend_w;
    assign bus_w.imem_rdata     = word_at(addr_w);
    assign bus_w.redirect_valid = 1'b0;
    assign bus_w.redirect_pc    = 32'h0;
    assign bus_w.out_ready      = 1'b1;

    always @(posedge clk) begin
        if (reset) begin
            pend_a   <= 1'b0;
            pend_w   <= 1'b0;
            addr_a   <= 32'h0;
            addr_w   <= 32'h0;
            grants_a <= 0;
        end else begin
            pend_a <= bus_a.imem_req && bus_a.imem_gnt;
            addr_a <= bus_a.imem_addr;
            pend_w <= bus_w.imem_req && bus_w.imem_gnt;
            addr_w <= bus_w.imem_addr;
            if (bus_a.imem_req && bus_a.imem_gnt) grants_a <= grants_a + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic g, input logic rv, input logic [31:0] rd,
                          input logic rdir, input logic [31:0] rpc, input logic rdy);
        gnt_m   = g;
        rv_m    = rv;
        rdata_m = rd;
        redir_m = rdir;
        rpc_m   = rpc;
        ready_m = rdy;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        mem_auto = 1'b1;
        gnt_m    = 1'b0;
        rv_m     = 1'b0;
        rdata_m  = 32'h0;
        redir_m  = 1'b0;
        rpc_m    = 32'h0;
        ready_m  = 1'b1;

        // Reset state
        tick();
        tick();
        check_eq("rst_req", bus_a.imem_req, 32'd0);
        check_eq("rst_addr", bus_a.imem_addr, 32'h0);
        check_eq("rst_valid", bus_a.out_valid, 32'd0);
        check_eq("rst_instr", bus_a.out_instr, 32'h0);
        check_eq("rst_pc", bus_a.out_pc, 32'h0);
        check_eq("rst_addr_wrap", bus_w.imem_addr, 32'hFFFF_FFFC);
        reset = 1'b0;
        #1;
        check_eq("first_req", bus_a.imem_req, 32'd1);
        check_eq("first_addr", bus_a.imem_addr, 32'h0);
        check_eq("first_req_wrap", bus_w.imem_req, 32'd1);

        // Straight line (both instances), one instruction every two cycles
        for (int k = 0; k < 4; k++) begin
            logic [31:0] e;
            logic [31:0] ew;
            e  = 32'(4 * k);
            ew = 32'hFFFF_FFFC + e;
            tick();
            tick();
            check_eq("line_valid", bus_a.out_valid, 32'd1);
            check_eq("line_pc", bus_a.out_pc, e);
            check_eq("line_instr", bus_a.out_instr, word_at(e));
            check_eq("wrap_pc", bus_w.out_pc, ew);
            check_eq("wrap_instr", bus_w.out_instr, word_at(ew));
        end

        // Backpressure: queue fills with pc 0,4 then requests stop
        ready_m = 1'b0;
        reset   = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (10) tick();
        check_eq("bp_grants", 32'(grants_a), 32'd2);
        check_eq("bp_req", bus_a.imem_req, 32'd0);
        check_eq("bp_addr", bus_a.imem_addr, 32'h8);
        check_eq("bp_head", bus_a.out_pc, 32'h0);
        ready_m = 1'b1;
        #1;
        tick();
        check_eq("bp_head2", bus_a.out_pc, 32'h4);
        check_eq("bp_resume_req", bus_a.imem_req, 32'd1);
        check_eq("bp_resume_addr", bus_a.imem_addr, 32'h8);
        tick();
        tick();
        check_eq("bp_pc8_valid", bus_a.out_valid, 32'd1);
        check_eq("bp_pc8", bus_a.out_pc, 32'h8);
        check_eq("bp_pc8_instr", bus_a.out_instr, word_at(32'h8));

        // Manual memory: redirect in WAIT without rvalid
        mem_auto = 1'b0;
        reset    = 1'b1;
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check_eq("m_req0", bus_a.imem_req, 32'd1);
        tick();
        set_in(1'b0, 1'b1, word_at(32'h0), 1'b0, 32'h0, 1'b0);
        check_eq("m_wait_req", bus_a.imem_req, 32'd0);
        tick();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check_eq("m_pc0", bus_a.out_pc, 32'h0);
        check_eq("m_addr4", bus_a.imem_addr, 32'h4);
        tick();
        set_in(1'b0, 1'b1, word_at(32'h4), 1'b0, 32'h0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("m_full_req", bus_a.imem_req, 32'd0);
        tick();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check_eq("m_req8", bus_a.imem_req, 32'd1);
        check_eq("m_addr8", bus_a.imem_addr, 32'h8);
        check_eq("m_head4", bus_a.out_pc, 32'h4);
        tick();
        set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
        check_eq("rd_wait_valid", bus_a.out_valid, 32'd1);
        tick();
        set_in(1'b0, 1'b1, word_at(32'h8), 1'b0, 32'h0, 1'b0);
        check_eq("rd_flush", bus_a.out_valid, 32'd0);
        check_eq("rd_drop_req", bus_a.imem_req, 32'd0);
        tick();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("rd_dropped", bus_a.out_valid, 32'd0);
        check_eq("rd_req", bus_a.imem_req, 32'd1);
        check_eq("rd_addr", bus_a.imem_addr, 32'h100);
        tick();
        set_in(1'b0, 1'b1, word_at(32'h100), 1'b0, 32'h0, 1'b1);
        tick();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("rd_pc100", bus_a.out_pc, 32'h100);
        check_eq("rd_instr100", bus_a.out_instr, word_at(32'h100));
        check_eq("rd_addr104", bus_a.imem_addr, 32'h104);
        tick();

        // Redirect coinciding with rvalid: data discarded, target realigned
        set_in(1'b0, 1'b1, 32'hDEAD_0104, 1'b1, 32'h202, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("rv_valid", bus_a.out_valid, 32'd0);
        check_eq("rv_req", bus_a.imem_req, 32'd1);
        check_eq("rv_addr", bus_a.imem_addr, 32'h200);
        tick();
        check_eq("rv_valid2", bus_a.out_valid, 32'd0);
        check_eq("rv_hold_addr", bus_a.imem_addr, 32'h200);

        // Reset while WAIT, stray rvalid right after release
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick();
        reset = 1'b1;
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick();
        check_eq("mr_req", bus_a.imem_req, 32'd0);
        check_eq("mr_addr", bus_a.imem_addr, 32'h0);
        reset = 1'b0;
        set_in(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
        check_eq("mr_first_req", bus_a.imem_req, 32'd1);
        tick();
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("mr_no_push", bus_a.out_valid, 32'd0);
        check_eq("mr_req2", bus_a.imem_req, 32'd1);
        check_eq("mr_addr2", bus_a.imem_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter QDEPTH, default 2, is the number of instruction-queue entries (legal 1..8).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  word-aligned fetch address; the iaddr consumed by the branch stage.
REQ-007 imem_gnt  input  1  memory accepts the request this cycle.
REQ-008 imem_rvalid  input  1  read data valid for the single outstanding request.
REQ-009 imem_rdata  input  32  fetched instruction word (idata).
REQ-010 redirect_valid  input  1  branch/jump taken; restart fetch.
REQ-011 redirect_pc  input  32  target PC from the branch stage (its iaddr_val output).
REQ-012 out_valid  output  1  queue head holds a valid instruction.
REQ-013 out_ready  input  1  downstream accepts the queue head.
REQ-014 out_instr  output  32  instruction word at queue head.
REQ-015 out_pc  output  32  PC of out_instr.

Function
REQ-016 FSM states: FETCH (may issue), WAIT (one request outstanding), DROP (outstanding response to be discarded).
REQ-017 At most one memory request outstanding at any time.
REQ-018 In FETCH, the block drives imem_req=1 only when queue occupancy is below QDEPTH and redirect_valid=0; imem_addr = fetch PC.
REQ-019 imem_req and imem_addr hold stable until imem_gnt; gnt with req=0 is ignored.
REQ-020 On req&gnt (no redirect): latch request PC, fetch PC += 4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0), go to WAIT.
REQ-021 In WAIT, imem_req=0; on imem_rvalid push {latched PC, imem_rdata} to queue tail, go to FETCH; next request no earlier than the following cycle.
REQ-022 imem_rvalid in FETCH is ignored.
REQ-023 Queue is FIFO; out_valid = (occupancy != 0); out_instr/out_pc show the head; pop when out_valid&out_ready.
REQ-024 Push and pop in the same cycle with queue full is legal; occupancy is unchanged.
REQ-025 Because issue requires free space (REQ-018), a push never overflows.
REQ-026 On redirect_valid: flush the queue (out_valid=0 next cycle) and set fetch PC = {redirect_pc[31:2],2'b00}.
REQ-027 Redirect in FETCH with req&gnt in the same cycle: the granted request is outstanding; go to DROP.
REQ-028 Redirect in WAIT without imem_rvalid: go to DROP.
REQ-029 Redirect in WAIT with imem_rvalid in the same cycle: the data is discarded; go to FETCH.
REQ-030 Redirect in FETCH with no grant: stay in FETCH.
REQ-031 Redirect in DROP updates fetch PC and remains in DROP.
REQ-032 In DROP, imem_req=0; on imem_rvalid discard the data, go to FETCH.
REQ-033 Redirect has priority over pop; a head popped in a redirect cycle is consumed by downstream, then the flush takes effect.
REQ-034 Fetch latency: the first request after a redirect is driven in the cycle after the redirect cycle.

Reset
REQ-035 While reset=1: state=FETCH, fetch PC=RESET_PC, queue empty, imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
REQ-036 In the first cycle after reset deasserts, imem_req=1 with imem_addr=RESET_PC.
REQ-037 Reset mid-operation discards any outstanding request and queue contents; imem_rvalid in the first cycle after reset is ignored.

Verification
REQ-038 Straight line: gnt every request, rvalid 1 cycle after gnt, out_ready=1 -> out_pc sequence 0,4,8,... with matching rdata.
REQ-039 Backpressure: out_ready=0, QDEPTH=2 -> exactly 2 pushes (pc 0,4), then imem_req stays 0; out_ready=1 resumes at pc 8.
REQ-040 Redirect while WAIT for pc 8 to redirect_pc=32'h100 -> pc 8 data dropped, queue flushed, next imem_addr=32'h100.
REQ-041 Redirect in the same cycle as rvalid with redirect_pc=32'h202 -> data discarded, next imem_addr=32'h200 in the cycle after.
REQ-042 Wrap: RESET_PC=32'hFFFF_FFFC -> out_pc FFFF_FFFC then 0000_0000.
REQ-043 Reset asserted in WAIT, then rvalid the cycle after release -> nothing pushed, imem_addr=RESET_PC.
